// File: rtl/multicycle_controller_pkg.sv
// Shared definitions for the multicycle controller.
//   - RV32 base opcodes handled by the controller
//   - FSM state encoding (also exported on the state port)
//   - ALU_OP constants and reg_data_mux encodings
//   - one-hot instruction class indices and the control-word struct
package multicycle_controller_pkg;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] F7_MULDIV  = 7'b0000001;

  typedef enum logic [2:0] {
    ST_FETCH  = 3'd0,
    ST_DECODE = 3'd1,
    ST_EXEC   = 3'd2,
    ST_MEM    = 3'd3,
    ST_WB     = 3'd4,
    ST_MDU    = 3'd5,
    ST_TRAP   = 3'd6
  } state_e;

  localparam logic [3:0] ALU_ADD = 4'b0000;
  localparam logic [3:0] ALU_BP  = 4'b0111;  // pass operand B (LUI)
  localparam logic [3:0] ALU_NOP = 4'b1111;

  localparam logic [1:0] RD_MEM = 2'b00;
  localparam logic [1:0] RD_ALU = 2'b01;
  localparam logic [1:0] RD_MDU = 2'b10;
  localparam logic [1:0] RD_PC4 = 2'b11;

  // one-hot instruction class bit positions
  localparam int CLS_R     = 0;
  localparam int CLS_I     = 1;
  localparam int CLS_STORE = 2;
  localparam int CLS_LOAD  = 3;
  localparam int CLS_BR    = 4;
  localparam int CLS_JALR  = 5;
  localparam int CLS_JAL   = 6;
  localparam int CLS_LUI   = 7;
  localparam int CLS_AUIPC = 8;
  localparam int CLS_MDU   = 9;
  localparam int CLS_W     = 10;

  typedef logic [CLS_W-1:0] cls_t;

  typedef struct packed {
    logic       imem_req;
    logic       ir_we;
    logic       pc_we;
    logic       pc_mux;
    logic       op1_mux;
    logic       op2_mux;
    logic [3:0] alu_op;
    logic [1:0] rd_mux;
    logic       reg_wr_en;
    logic       dmem_req;
    logic       mem_wr_en;
    logic [2:0] mem_control;
    logic       mdu_start;
  } ctl_t;

  // ALU operation for the EXEC cycle of a given class.
  // Only shifts-right carry funct7[5] for OP-IMM (SRLI/SRAI); for the other
  // immediates that bit is part of the immediate and must be ignored.
  function automatic logic [3:0] alu_op_sel(input cls_t cls, input logic [2:0] f3,
                                            input logic f7b5);
    logic [3:0] op;
    op = ALU_NOP;
    if (cls[CLS_R])
      op = {f3, f7b5};
    else if (cls[CLS_I])
      op = (f3 == 3'b101) ? {f3, f7b5} : {f3, 1'b0};
    else if (cls[CLS_LOAD] | cls[CLS_STORE] | cls[CLS_BR] | cls[CLS_JAL] |
             cls[CLS_JALR] | cls[CLS_AUIPC])
      op = ALU_ADD;
    else if (cls[CLS_LUI])
      op = ALU_BP;
    return op;
  endfunction

endpackage

// File: rtl/multicycle_controller_decode.sv
// instr_class_decode: combinational opcode classifier.
//   opcode, funct7 -> cls (one-hot class), legal (exactly one class bit set)
// The M-extension encoding is its own class when M_EXT=1 and illegal otherwise.
module instr_class_decode
  import multicycle_controller_pkg::*;
#(
  parameter int M_EXT = 0
) (
  input  logic [6:0] opcode,
  input  logic [6:0] funct7,
  output cls_t       cls,
  output logic       legal
);

  always_comb begin
    cls = '0;
    case (opcode)
      OPC_OP: begin
        if (funct7 == F7_MULDIV) begin
          if (M_EXT != 0) cls[CLS_MDU] = 1'b1;
        end else begin
          cls[CLS_R] = 1'b1;
        end
      end
      OPC_OP_IMM: cls[CLS_I]     = 1'b1;
      OPC_STORE:  cls[CLS_STORE] = 1'b1;
      OPC_LOAD:   cls[CLS_LOAD]  = 1'b1;
      OPC_BRANCH: cls[CLS_BR]    = 1'b1;
      OPC_JALR:   cls[CLS_JALR]  = 1'b1;
      OPC_JAL:    cls[CLS_JAL]   = 1'b1;
      OPC_LUI:    cls[CLS_LUI]   = 1'b1;
      OPC_AUIPC:  cls[CLS_AUIPC] = 1'b1;
      default:    ;
    endcase
  end

  assign legal = |cls;

endmodule

// File: rtl/multicycle_controller.sv
// multicycle_controller: FSM sequencing a multicycle RV32 datapath.
//   Inputs : IR fields (opcode/funct3/funct7), branch_taken, imem_ready,
//            dmem_ready, mdu_done
//   Outputs: fetch/PC/IR strobes, ALU operand/op selects, writeback select,
//            data memory strobes, mdu_start, sticky illegal_instr/bus_error,
//            current state.
// The datapath is assumed to register the ALU result, so ALU controls are
// only driven during EXEC. Memory waits are bounded by MEM_TIMEOUT; a ready
// arriving after exactly MEM_TIMEOUT wait cycles is still accepted.
module multicycle_controller
  import multicycle_controller_pkg::*;
#(
  parameter int M_EXT       = 0,
  parameter int MEM_TIMEOUT = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [6:0] opcode,
  input  logic [2:0] funct3,
  input  logic [6:0] funct7,
  input  logic       branch_taken,
  input  logic       imem_ready,
  input  logic       dmem_ready,
  input  logic       mdu_done,
  output logic       imem_req,
  output logic       ir_we,
  output logic       pc_we,
  output logic       PC_mux,
  output logic       ALU_OP1_mux,
  output logic       ALU_OP2_mux,
  output logic [3:0] ALU_OP,
  output logic [1:0] reg_data_mux,
  output logic       reg_wr_en,
  output logic       dmem_req,
  output logic       mem_wr_en,
  output logic [2:0] mem_control,
  output logic       mdu_start,
  output logic       illegal_instr,
  output logic       bus_error,
  output logic [2:0] state
);

  localparam logic [7:0] TO = 8'(MEM_TIMEOUT);

  state_e     state_q, state_n;
  logic [7:0] cnt_q;
  logic       ill_q, berr_q;
  logic       set_ill, set_berr;
  logic       waiting, timed_out;
  cls_t       cls;
  logic       legal;
  ctl_t       c;

  instr_class_decode #(.M_EXT(M_EXT)) u_dec (
    .opcode (opcode),
    .funct7 (funct7),
    .cls    (cls),
    .legal  (legal)
  );

  // cnt_q = wait cycles already spent in the current FETCH/MEM visit
  assign waiting   = ((state_q == ST_FETCH) && !imem_ready) ||
                     ((state_q == ST_MEM)   && !dmem_ready);
  assign timed_out = (cnt_q == TO);

  always_comb begin
    state_n       = state_q;
    set_ill       = 1'b0;
    set_berr      = 1'b0;
    c             = '0;
    c.alu_op      = ALU_NOP;
    c.rd_mux      = RD_ALU;
    c.mem_control = 3'b010;
    unique case (state_q)
      ST_FETCH: begin
        c.imem_req = 1'b1;
        if (imem_ready) begin
          c.ir_we = 1'b1;
          state_n = ST_DECODE;
        end else if (timed_out) begin
          set_berr = 1'b1;
          state_n  = ST_TRAP;
        end
      end
      ST_DECODE: begin
        if (!legal) begin
          set_ill = 1'b1;
          state_n = ST_TRAP;
        end else if (cls[CLS_MDU]) begin
          c.mdu_start = 1'b1;
          state_n     = ST_MDU;
        end else begin
          state_n = ST_EXEC;
        end
      end
      ST_EXEC: begin
        c.alu_op  = alu_op_sel(cls, funct3, funct7[5]);
        c.op1_mux = cls[CLS_BR] | cls[CLS_JAL] | cls[CLS_AUIPC];
        c.op2_mux = cls[CLS_R];
        if (cls[CLS_LOAD] | cls[CLS_STORE]) begin
          state_n = ST_MEM;
        end else if (cls[CLS_BR]) begin
          // branch retires here: no writeback cycle
          c.pc_we  = 1'b1;
          c.pc_mux = branch_taken;
          state_n  = ST_FETCH;
        end else begin
          state_n = ST_WB;
        end
      end
      ST_MEM: begin
        c.dmem_req    = 1'b1;
        c.mem_control = funct3;
        c.mem_wr_en   = cls[CLS_STORE];
        if (dmem_ready) begin
          if (cls[CLS_STORE]) begin
            c.pc_we = 1'b1;
            state_n = ST_FETCH;
          end else begin
            state_n = ST_WB;
          end
        end else if (timed_out) begin
          set_berr = 1'b1;
          state_n  = ST_TRAP;
        end
      end
      ST_WB: begin
        c.reg_wr_en = 1'b1;
        c.pc_we     = 1'b1;
        c.pc_mux    = cls[CLS_JAL] | cls[CLS_JALR];
        if (cls[CLS_LOAD])                    c.rd_mux = RD_MEM;
        else if (cls[CLS_JAL] | cls[CLS_JALR]) c.rd_mux = RD_PC4;
        else if (cls[CLS_MDU])                c.rd_mux = RD_MDU;
        else                                  c.rd_mux = RD_ALU;
        state_n = ST_FETCH;
      end
      ST_MDU: begin
        if (mdu_done) state_n = ST_WB;
      end
      ST_TRAP: ;
      default: state_n = ST_FETCH;  // unused encoding: recover
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_FETCH;
      cnt_q   <= '0;
      ill_q   <= 1'b0;
      berr_q  <= 1'b0;
    end else begin
      state_q <= state_n;
      if (state_n != state_q) cnt_q <= '0;
      else if (waiting)       cnt_q <= cnt_q + 8'd1;
      if (set_ill)  ill_q  <= 1'b1;
      if (set_berr) berr_q <= 1'b1;
    end
  end

  assign imem_req      = c.imem_req;
  assign ir_we         = c.ir_we;
  assign pc_we         = c.pc_we;
  assign PC_mux        = c.pc_mux;
  assign ALU_OP1_mux   = c.op1_mux;
  assign ALU_OP2_mux   = c.op2_mux;
  assign ALU_OP        = c.alu_op;
  assign reg_data_mux  = c.rd_mux;
  assign reg_wr_en     = c.reg_wr_en;
  assign dmem_req      = c.dmem_req;
  assign mem_wr_en     = c.mem_wr_en;
  assign mem_control   = c.mem_control;
  assign mdu_start     = c.mdu_start;
  assign illegal_instr = ill_q;
  assign bus_error     = berr_q;
  assign state         = state_q;

endmodule
